// File: rtl/in_decode_if.sv
`default_nettype none
//==============================================================================
// Module   : in_decode_if
// Brief    : Fetch-side inputs, writeback port and ID/EX outputs of the decode stage.
// Revision : 1.0
//==============================================================================
interface in_decode_if #(
   parameter int XLEN = 32
) ();
   // fetch / control inputs
   logic [31:0]     instruction_in;
   logic [XLEN-1:0] PC_in;
   logic            flush;
   // writeback port
   logic            RegWrite_wb;
   logic [4:0]      rd_wb;
   logic [XLEN-1:0] wdata_wb;
   // stall back to fetch
   logic            PCWrite;
   logic            IF_ID_Write;
   // ID/EX register
   logic [XLEN-1:0] PC_out;
   logic [XLEN-1:0] rs1_data_out;
   logic [XLEN-1:0] rs2_data_out;
   logic [XLEN-1:0] imm_out;
   logic [4:0]      rs1_out;
   logic [4:0]      rs2_out;
   logic [4:0]      rd_out;
   logic [2:0]      funct3_out;
   logic            funct7b5_out;
   logic            ALUSrc;
   logic            Branch;
   logic            Jump;
   logic            MemRead;
   logic            MemWrite;
   logic            MemtoReg;
   logic            RegWrite;
   logic [1:0]      ALUOp;
   logic            illegal_out;

   modport slave (
      input  instruction_in, PC_in, flush, RegWrite_wb, rd_wb, wdata_wb,
      output PCWrite, IF_ID_Write, PC_out, rs1_data_out, rs2_data_out, imm_out,
             rs1_out, rs2_out, rd_out, funct3_out, funct7b5_out, ALUSrc, Branch,
             Jump, MemRead, MemWrite, MemtoReg, RegWrite, ALUOp, illegal_out
   );

   modport master (
      output instruction_in, PC_in, flush, RegWrite_wb, rd_wb, wdata_wb,
      input  PCWrite, IF_ID_Write, PC_out, rs1_data_out, rs2_data_out, imm_out,
             rs1_out, rs2_out, rd_out, funct3_out, funct7b5_out, ALUSrc, Branch,
             Jump, MemRead, MemWrite, MemtoReg, RegWrite, ALUOp, illegal_out
   );
endinterface
`default_nettype wire

// File: rtl/in_decode.sv
`default_nettype none
//==============================================================================
// Module   : in_decode
// Brief    : RV32I decode stage: register file, immediate generator, control
//            decoder, load-use hazard detector and ID/EX pipeline register.
//            Optional macro ID_RF_BYPASS_EN enables write-before-read forwarding.
// Revision : 1.0
//==============================================================================
module in_decode #(
   parameter int XLEN = 32,
   parameter int NREG = 32
) (
   input wire         clk,
   input wire         reset,
   in_decode_if.slave bus
);

   localparam logic [6:0] c_OP_R      = 7'b0110011;
   localparam logic [6:0] c_OP_IMM    = 7'b0010011;
   localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
   localparam logic [6:0] c_OP_STORE  = 7'b0100011;
   localparam logic [6:0] c_OP_BRANCH = 7'b1100011;
   localparam logic [6:0] c_OP_JAL    = 7'b1101111;
   localparam logic [6:0] c_OP_JALR   = 7'b1100111;
   localparam logic [6:0] c_OP_LUI    = 7'b0110111;
   localparam logic [6:0] c_OP_AUIPC  = 7'b0010111;

   localparam logic [1:0] c_ALU_ADD   = 2'b00;
   localparam logic [1:0] c_ALU_BR    = 2'b01;
   localparam logic [1:0] c_ALU_R     = 2'b10;
   localparam logic [1:0] c_ALU_I     = 2'b11;

   localparam logic [2:0] c_IMM_NONE  = 3'd0;
   localparam logic [2:0] c_IMM_I     = 3'd1;
   localparam logic [2:0] c_IMM_S     = 3'd2;
   localparam logic [2:0] c_IMM_B     = 3'd3;
   localparam logic [2:0] c_IMM_J     = 3'd4;
   localparam logic [2:0] c_IMM_U     = 3'd5;

   logic [31:0]     w_instr;
   logic [6:0]      w_opcode;
   logic [4:0]      w_rs1;
   logic [4:0]      w_rs2;
   logic [4:0]      w_rd;

   logic            w_alusrc;
   logic            w_branch;
   logic            w_jump;
   logic            w_memread;
   logic            w_memwrite;
   logic            w_memtoreg;
   logic            w_regwrite;
   logic [1:0]      w_aluop;
   logic            w_illegal;
   logic [2:0]      w_imm_sel;
   logic [XLEN-1:0] w_imm;

   logic [XLEN-1:0] r_regs [NREG];
   logic            w_wb_en;
   logic            w_fwd_rs1;
   logic            w_fwd_rs2;
   logic [XLEN-1:0] w_rs1_data;
   logic [XLEN-1:0] w_rs2_data;

   logic            w_load_use;
   logic            w_bubble;

   assign w_instr  = bus.instruction_in;
   assign w_opcode = w_instr[6:0];
   assign w_rs1    = w_instr[19:15];
   assign w_rs2    = w_instr[24:20];
   assign w_rd     = w_instr[11:7];

   //---------------------------------------------------------------------------
   // Main control decoder
   //---------------------------------------------------------------------------
   always_comb begin
      w_alusrc   = 1'b0;
      w_branch   = 1'b0;
      w_jump     = 1'b0;
      w_memread  = 1'b0;
      w_memwrite = 1'b0;
      w_memtoreg = 1'b0;
      w_regwrite = 1'b0;
      w_aluop    = c_ALU_ADD;
      w_illegal  = 1'b0;
      w_imm_sel  = c_IMM_NONE;
      case (w_opcode)
         c_OP_R: begin
            w_regwrite = 1'b1;
            w_aluop    = c_ALU_R;
         end
         c_OP_IMM: begin
            w_regwrite = 1'b1;
            w_alusrc   = 1'b1;
            w_aluop    = c_ALU_I;
            w_imm_sel  = c_IMM_I;
         end
         c_OP_LOAD: begin
            w_memread  = 1'b1;
            w_memtoreg = 1'b1;
            w_regwrite = 1'b1;
            w_alusrc   = 1'b1;
            w_imm_sel  = c_IMM_I;
         end
         c_OP_STORE: begin
            w_memwrite = 1'b1;
            w_alusrc   = 1'b1;
            w_imm_sel  = c_IMM_S;
         end
         c_OP_BRANCH: begin
            w_branch   = 1'b1;
            w_aluop    = c_ALU_BR;
            w_imm_sel  = c_IMM_B;
         end
         c_OP_JAL: begin
            w_jump     = 1'b1;
            w_regwrite = 1'b1;
            w_imm_sel  = c_IMM_J;
         end
         c_OP_JALR: begin
            w_jump     = 1'b1;
            w_regwrite = 1'b1;
            w_alusrc   = 1'b1;
            w_imm_sel  = c_IMM_I;
         end
         c_OP_LUI, c_OP_AUIPC: begin
            w_regwrite = 1'b1;
            w_alusrc   = 1'b1;
            w_imm_sel  = c_IMM_U;
         end
         // the all-zero word is fetch's reset filler, a bubble but not illegal
         default: w_illegal = |w_instr;
      endcase
   end

   //---------------------------------------------------------------------------
   // Immediate generator (sign taken from instruction bit 31)
   //---------------------------------------------------------------------------
   always_comb begin
      w_imm = '0;
      case (w_imm_sel)
         c_IMM_I: w_imm = {{20{w_instr[31]}}, w_instr[31:20]};
         c_IMM_S: w_imm = {{20{w_instr[31]}}, w_instr[31:25], w_instr[11:7]};
         c_IMM_B: w_imm = {{19{w_instr[31]}}, w_instr[31], w_instr[7],
                           w_instr[30:25], w_instr[11:8], 1'b0};
         c_IMM_J: w_imm = {{11{w_instr[31]}}, w_instr[31], w_instr[19:12],
                           w_instr[20], w_instr[30:21], 1'b0};
         c_IMM_U: w_imm = {w_instr[31:12], 12'h000};
         default: w_imm = '0;
      endcase
   end

   //---------------------------------------------------------------------------
   // Register file: x0 is never written and always reads zero
   //---------------------------------------------------------------------------
   assign w_wb_en = bus.RegWrite_wb && (bus.rd_wb != 5'd0);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < NREG; i++) begin
            r_regs[i] <= '0;
         end
      end else if (w_wb_en) begin
         r_regs[bus.rd_wb] <= bus.wdata_wb;
      end
   end

`ifdef ID_RF_BYPASS_EN
   assign w_fwd_rs1 = w_wb_en && (bus.rd_wb == w_rs1);
   assign w_fwd_rs2 = w_wb_en && (bus.rd_wb == w_rs2);
`else
   assign w_fwd_rs1 = 1'b0;
   assign w_fwd_rs2 = 1'b0;
`endif

   always_comb begin
      w_rs1_data = r_regs[w_rs1];
      if (w_rs1 == 5'd0) begin
         w_rs1_data = '0;
      end else if (w_fwd_rs1) begin
         w_rs1_data = bus.wdata_wb;
      end
   end

   always_comb begin
      w_rs2_data = r_regs[w_rs2];
      if (w_rs2 == 5'd0) begin
         w_rs2_data = '0;
      end else if (w_fwd_rs2) begin
         w_rs2_data = bus.wdata_wb;
      end
   end

   //---------------------------------------------------------------------------
   // Load-use hazard: a redirect overrides the stall so the new path proceeds
   //---------------------------------------------------------------------------
   assign w_load_use = bus.MemRead && (bus.rd_out != 5'd0) &&
                       ((bus.rd_out == w_rs1) || (bus.rd_out == w_rs2)) &&
                       !bus.flush;
   assign w_bubble   = bus.flush || w_load_use;

   assign bus.PCWrite     = !w_load_use;
   assign bus.IF_ID_Write = !w_load_use;

   //---------------------------------------------------------------------------
   // ID/EX pipeline register
   //---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         bus.PC_out       <= '0;
         bus.rs1_data_out <= '0;
         bus.rs2_data_out <= '0;
         bus.imm_out      <= '0;
         bus.rs1_out      <= '0;
         bus.rs2_out      <= '0;
         bus.rd_out       <= '0;
         bus.funct3_out   <= '0;
         bus.funct7b5_out <= 1'b0;
      end else begin
         bus.PC_out       <= bus.PC_in;
         bus.rs1_data_out <= w_rs1_data;
         bus.rs2_data_out <= w_rs2_data;
         bus.imm_out      <= w_imm;
         bus.rs1_out      <= w_rs1;
         bus.rs2_out      <= w_rs2;
         bus.rd_out       <= w_rd;
         bus.funct3_out   <= w_instr[14:12];
         bus.funct7b5_out <= w_instr[30];
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         bus.ALUSrc      <= 1'b0;
         bus.Branch      <= 1'b0;
         bus.Jump        <= 1'b0;
         bus.MemRead     <= 1'b0;
         bus.MemWrite    <= 1'b0;
         bus.MemtoReg    <= 1'b0;
         bus.RegWrite    <= 1'b0;
         bus.ALUOp       <= c_ALU_ADD;
         bus.illegal_out <= 1'b0;
      end else if (w_bubble) begin
         bus.ALUSrc      <= 1'b0;
         bus.Branch      <= 1'b0;
         bus.Jump        <= 1'b0;
         bus.MemRead     <= 1'b0;
         bus.MemWrite    <= 1'b0;
         bus.MemtoReg    <= 1'b0;
         bus.RegWrite    <= 1'b0;
         bus.ALUOp       <= c_ALU_ADD;
         bus.illegal_out <= 1'b0;
      end else begin
         bus.ALUSrc      <= w_alusrc;
         bus.Branch      <= w_branch;
         bus.Jump        <= w_jump;
         bus.MemRead     <= w_memread;
         bus.MemWrite    <= w_memwrite;
         bus.MemtoReg    <= w_memtoreg;
         bus.RegWrite    <= w_regwrite;
         bus.ALUOp       <= w_aluop;
         bus.illegal_out <= w_illegal;
      end
   end

endmodule
`default_nettype wire

// File: doc/in_decode.md
Name: in_decode

Overview:
- RV32I decode stage directly downstream of instruction fetch.
- Consumes the fetched instruction and its PC, both already aligned by fetch's one-cycle BRAM latency.
- Contains the 32x32 register file, immediate generator, main control decoder and load-use hazard detector.
- Drives the ID/EX pipeline register and issues the stall signals back to fetch (PC hold, IF/ID hold).

Parameters:
- XLEN, 32, datapath width.
- NREG, 32, register count; x0 is hardwired to zero.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low; clears the register file and all ID/EX outputs.
- instruction_in  in  32  instruction from fetch.
- PC_in  in  32  PC of instruction_in.
- flush  in  1  branch/jump taken (PCSrc); current ID instruction is wrong-path.
- RegWrite_wb  in  1  writeback enable.
- rd_wb  in  5  writeback destination.
- wdata_wb  in  32  writeback data.
- PCWrite  out  1  0 = fetch holds PC.
- IF_ID_Write  out  1  0 = fetch holds instruction/PC.
- PC_out  out  32  ID/EX PC.
- rs1_data_out, rs2_data_out  out  32 each  operand values.
- imm_out  out  32  sign-extended immediate.
- rs1_out, rs2_out, rd_out  out  5 each  register indices.
- funct3_out  out  3  instruction[14:12].
- funct7b5_out  out  1  instruction[30].
- ALUSrc, Branch, Jump, MemRead, MemWrite, MemtoReg, RegWrite  out  1 each  control.
- ALUOp  out  2  00 add, 01 branch compare, 10 R-type, 11 I-ALU.
- illegal_out  out  1  unknown opcode flag.

Behaviour:
Reset:
- Asserting reset (low) immediately zeroes every ID/EX output and all 32 registers.
- PCWrite and IF_ID_Write read 1 during reset.
- Reset mid-stall clears the hazard, because MemRead_out returns to 0.

Decode (combinational, captured at posedge; 1-cycle latency to ID/EX):
- R 0110011: RegWrite, ALUOp 10.
- OP-IMM 0010011: RegWrite, ALUSrc, ALUOp 11, I-imm.
- LOAD 0000011: MemRead, MemtoReg, RegWrite, ALUSrc, ALUOp 00, I-imm.
- STORE 0100011: MemWrite, ALUSrc, ALUOp 00, S-imm.
- BRANCH 1100011: Branch, ALUOp 01, B-imm (bit0 = 0).
- JAL 1101111: Jump, RegWrite, ALUOp 00, J-imm.
- JALR 1100111: Jump, RegWrite, ALUSrc, ALUOp 00, I-imm.
- LUI 0110111 and AUIPC 0010111: RegWrite, ALUSrc, ALUOp 00, U-imm (imm[31:12] = instr[31:12], low 12 bits zero).
- Immediates are sign-extended from instruction[31].
- Any other opcode is a bubble with illegal_out = 1.
- All-zero instruction (fetch's reset output) is a bubble with illegal_out = 0.

Register file:
- Written at posedge when RegWrite_wb=1 and rd_wb != 0.
- Reads are asynchronous; index 0 always reads 0.

Hazard detection:
- load_use = MemRead & (rd_out != 0) & (rd_out == instr[19:15] | rd_out == instr[24:20]) & ~flush.
- PCWrite = IF_ID_Write = ~load_use (combinational).

ID/EX update, priority reset > flush > load_use > normal:
- flush or load_use: all control bits and illegal_out forced to 0 (bubble). Data fields still load but are don't-care.
- Normal: every field loads from the current decode.
- flush and load_use together: bubble, PCWrite = 1 (redirect proceeds).
- A load_use stall lasts exactly one cycle; the bubble clears MemRead.

Optional Feature:
- ID_RF_BYPASS_EN defined: a same-cycle writeback to rs1/rs2 (rd_wb != 0) is forwarded to rs1_data_out/rs2_data_out, i.e. write-before-read.
- ID_RF_BYPASS_EN undefined: the read returns the pre-write value. Software or the hazard unit must then cover the 3-instruction writeback gap.

Test Plan:
- Reset low mid-run with x5 = 0x1234 -> all outputs 0 immediately; x5 reads 0 after release; PCWrite = 1.
- ADDI x1,x0,-5 (0xFFB00093), PC_in = 0x10 -> next cycle imm_out = 0xFFFFFFFB, rd_out = 1, RegWrite = 1, ALUSrc = 1, ALUOp = 11, PC_out = 0x10.
- LW x2,0(x1) followed by ADD x3,x2,x2 -> one cycle with PCWrite = 0 and IF_ID_Write = 0; the ADD's ID/EX slot is a bubble and the ADD issues the following cycle.
- Branch in ID with flush = 1 while load_use is true -> ID/EX holds a bubble; PCWrite = 1.
- RegWrite_wb = 1, rd_wb = 7, wdata_wb = 0xCAFEBABE, same cycle as ADD x8,x7,x0 -> rs1_data_out = 0xCAFEBABE with ID_RF_BYPASS_EN, old x7 without it. A write to rd_wb = 0 leaves x0 reading 0.
- Opcode 0x7F -> illegal_out = 1 with all control bits 0. Instruction 0x00000000 -> illegal_out = 0, bubble.
